// File: rtl/matrix_mult_seq.sv
// N x N unsigned matrix multiplier built around one shared MAC unit.
// Operands are loaded through a write port; C streams out over valid/ready.
module matrix_mult_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic                  load_sel,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic [ADDR_WIDTH-1:0] res_index
);
    localparam int NN = N * N;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT, DONE} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] a_mem [NN];
    logic [DATA_WIDTH-1:0] b_mem [NN];
    logic [ACC_WIDTH-1:0]  c_mem [NN];
    logic [CW-1:0]         i, j, k;
    logic [ACC_WIDTH-1:0]  acc, acc_next;
    logic [ADDR_WIDTH-1:0] idx, a_idx, b_idx, c_idx;
    logic                  load_hit, k_last, j_last, i_last, idx_last;

    // Handshake: a result element transfers on the clk edge where res_valid
    // and res_ready are both high; res_data/res_index hold while stalled.
    assign load_ready = (state == IDLE) || (state == DONE);
    assign busy       = (state == COMPUTE) || (state == OUTPUT);
    assign done       = (state == DONE);
    assign res_valid  = (state == OUTPUT);
    assign res_data   = (state == OUTPUT) ? c_mem[idx] : '0;
    assign res_index  = (state == OUTPUT) ? idx : '0;

    assign a_idx    = ADDR_WIDTH'(i) * ADDR_WIDTH'(N) + ADDR_WIDTH'(k);
    assign b_idx    = ADDR_WIDTH'(k) * ADDR_WIDTH'(N) + ADDR_WIDTH'(j);
    assign c_idx    = ADDR_WIDTH'(i) * ADDR_WIDTH'(N) + ADDR_WIDTH'(j);
    assign k_last   = (k == CW'(N - 1));
    assign j_last   = (j == CW'(N - 1));
    assign i_last   = (i == CW'(N - 1));
    assign idx_last = (idx == ADDR_WIDTH'(NN - 1));
    // Extra bit on the compare so NN == 2**ADDR_WIDTH still admits every address.
    assign load_hit = load_valid && load_ready &&
                      ({1'b0, load_addr} < (ADDR_WIDTH + 1)'(NN));
    assign acc_next = ((k == '0) ? '0 : acc) +
                      ACC_WIDTH'(a_mem[a_idx]) * ACC_WIDTH'(b_mem[b_idx]);

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_next = COMPUTE;
                COMPUTE:    if (k_last && j_last && i_last) state_next = OUTPUT;
                OUTPUT:     if (res_ready && idx_last) state_next = DONE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            idx   <= '0;
            for (int n = 0; n < NN; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
                c_mem[n] <= '0;
            end
        end else begin
            state <= state_next;
            if (load_hit) begin
                if (load_sel) b_mem[load_addr] <= load_data;
                else          a_mem[load_addr] <= load_data;
            end
            if (!abort) begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            i   <= '0;
                            j   <= '0;
                            k   <= '0;
                            acc <= '0;
                            idx <= '0;
                        end
                    end
                    COMPUTE: begin
                        acc <= acc_next;
                        if (k_last) begin
                            c_mem[c_idx] <= acc_next;
                            k <= '0;
                            if (j_last) begin
                                j <= '0;
                                i <= i_last ? '0 : i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                    OUTPUT: begin
                        if (res_ready) idx <= idx_last ? '0 : idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
- Parametrised N×N unsigned matrix multiplier; computes C = A × B using one shared multiply-accumulate (MAC) unit.
- A and B are written through a load port.
- C is streamed out element by element with a valid/ready handshake.
- Successor to the fixed 3×3 LED-demo multiplier: configurable size and widths, runtime-loadable operands, backpressure, abort.

Parameters:
- DATA_WIDTH, 8, width of each A/B element (unsigned).
- N, 3, matrix dimension (N ≥ 2); each matrix holds N*N elements.
- ADDR_WIDTH, 4, element-address width; must satisfy 2^ADDR_WIDTH ≥ N*N.
- ACC_WIDTH, 18, accumulator and result width; must be ≥ 2*DATA_WIDTH + ceil(log2(N)).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  write strobe for the operand memories
- load_sel  in  1  0 = write A, 1 = write B
- load_addr  in  ADDR_WIDTH  row-major element index (i*N+j)
- load_data  in  DATA_WIDTH  element value
- load_ready  out  1  high while in IDLE or DONE (writes are accepted)
- start  in  1  begin computation (pulse or level)
- abort  in  1  synchronous abort back to IDLE
- busy  out  1  high in COMPUTE and OUTPUT
- done  out  1  high in DONE
- res_valid  out  1  result element valid
- res_ready  in  1  downstream accepts the result element
- res_data  out  ACC_WIDTH  C element value
- res_index  out  ADDR_WIDTH  row-major index of res_data

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All A, B and C entries cleared to 0.
  - Outputs: load_ready=1, busy=0, done=0, res_valid=0, res_data=0, res_index=0.
  - All loop counters cleared to 0.
- States: IDLE, COMPUTE, OUTPUT, DONE.
- Load (IDLE or DONE only):
  - On load_valid at a clk edge, the selected memory[load_addr] is written with load_data.
  - load_addr ≥ N*N: write ignored, no other effect.
  - load_valid in COMPUTE or OUTPUT: ignored.
- IDLE/DONE → COMPUTE:
  - Triggered by start=1 with abort=0.
  - A load write in the same cycle commits first; the computation uses the updated value.
  - Entering COMPUTE: i, j, k and the accumulator are cleared; done drops to 0; busy rises the following cycle.
- COMPUTE, one MAC per cycle:
  - Each cycle: acc ← (k==0 ? 0 : acc) + A[i*N+k]*B[k*N+j].
  - When k==N-1, the final sum is written to C[i*N+j]. Then k wraps to 0 and j increments; when j wraps, i increments.
  - Exactly N^3 cycles are spent in COMPUTE, then the block moves to OUTPUT.
  - Arithmetic is unsigned, full precision, with no truncation at the given widths.
- OUTPUT:
  - res_valid=1, res_data=C[idx], res_index=idx, starting at idx=0.
  - On res_valid && res_ready, idx increments and the next element is presented the following cycle.
  - Holding res_ready=1 gives one element per cycle.
  - res_data and res_index stay stable while res_valid=1 and res_ready=0.
  - After the handshake at idx=N*N-1: res_valid=0, the block moves to DONE, done=1.
- DONE:
  - done stays high until start, abort or rst.
  - C is retained until the next computation or reset.
  - start re-runs the computation with the current A/B contents.
- start in COMPUTE or OUTPUT: ignored.
- abort (any state):
  - Next state is IDLE; busy=0, done=0, res_valid=0.
  - A and B are retained; C content is undefined.
  - abort has priority over start in the same cycle.
- Latency:
  - start sampled at edge t: first res_valid at edge t+N^3+1.
  - With res_ready=1 throughout: done=1 at edge t+N^3+N*N+1.

Test Plan:
- Defaults. Load A=1..9 and B=9..1 row-major, then pulse start, with res_ready=1. Required: res_data sequence 30,24,18,84,69,54,138,114,90 with res_index 0..8; busy high for 27+9 cycles; done asserted after the last element.
- Worst case. All A and B elements = 255. Required: every res_data = 195075, proving no overflow in ACC_WIDTH=18.
- Backpressure. Toggle res_ready pseudo-randomly during OUTPUT. Required: each index 0..8 appears exactly once, in order, and res_data/res_index are held stable while stalled.
- Ignored inputs:
  - Assert start and load_valid (A[0]=99) mid-COMPUTE. Required: the result equals the original product.
  - Load at load_addr=12. Required: no memory change.
- Abort and reset:
  - Assert abort at COMPUTE cycle 10. Required: IDLE next cycle, res_valid never asserted; a subsequent start produces the correct C.
  - Assert rst mid-OUTPUT. Required: all outputs at reset values immediately; A/B read back as 0, so C = all zeros.
- N=4, ADDR_WIDTH=4, ACC_WIDTH=18. Load A=identity and B=1..16. Required: C=1..16 with COMPUTE lasting 64 cycles.
